ps2_keycode_rx: RTL and testbench
=================================

PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: the block SHALL treat the synchronized PS2Clk level as changed only after it holds for this many consecutive Clock cycles.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: the block SHALL abort any frame that spends more than this many Clock cycles between filtered falling edges.
REQ-003 Clock  input  1  system clock, 100 MHz; all logic SHALL be on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 PS2Clk  input  1  raw keyboard clock, asynchronous to Clock.
REQ-006 PS2Data  input  1  raw keyboard data, asynchronous to Clock.
REQ-007 Keycode  output  8  last accepted scan byte, held until the next accepted byte.
REQ-008 Enable  output  1  single-cycle strobe marking a newly accepted Keycode.
REQ-009 FrameErr  output  1  single-cycle strobe marking a discarded frame.

Function
REQ-010 PS2Clk and PS2Data SHALL each pass through a 2-flop synchronizer; the glitch filter of REQ-001 SHALL then be applied to PS2Clk.
REQ-011 A filtered 1->0 transition of PS2Clk SHALL be a bit event, and synchronized PS2Data SHALL be sampled in that same cycle.
REQ-012 The FSM SHALL have exactly four states: IDLE, DATA, PARITY, STOP.
REQ-013 In IDLE, a bit event with data 0 SHALL go to DATA and clear the bit counter; a bit event with data 1 SHALL stay in IDLE and SHALL NOT raise FrameErr.
REQ-014 DATA SHALL shift in 8 bits LSB first and SHALL go to PARITY on the 8th bit event.
REQ-015 On its bit event, PARITY SHALL latch the parity bit and go to STOP.
REQ-016 On its bit event, STOP SHALL return to IDLE; if the frame is valid it SHALL update Keycode and pulse Enable in the next cycle.
REQ-017 A frame is valid when the stop bit = 1 and the 8 data bits plus the parity bit hold an odd number of ones.
REQ-018 An invalid frame SHALL leave Keycode unchanged, SHALL NOT pulse Enable, and SHALL pulse FrameErr once in the cycle Enable would have pulsed.
REQ-019 A timeout counter SHALL run in every state except IDLE and SHALL clear on each bit event; at TIMEOUT_CYCLES it SHALL force IDLE and pulse FrameErr once.
REQ-020 If a timeout and a bit event fall on the same cycle, the bit event SHALL take precedence.
REQ-021 Enable and FrameErr SHALL never be high in the same cycle.
REQ-022 Keycode values (including 0xF0, 0x5A, 0x76, 0x72, 0x75) SHALL be passed through with no interpretation; break/make decoding stays downstream.
REQ-023 Latency from the raw PS2Clk falling edge of the stop bit to Enable SHALL be 2 + FILTER_LEN + 1 Clock cycles, within +/-1 cycle.

Reset
REQ-024 Reset SHALL set: state IDLE; Keycode 0x00; Enable 0; FrameErr 0; shift register, bit counter and timeout counter 0; filtered PS2Clk 1; synchronizer flops 1.
REQ-025 Reset during a frame SHALL discard the partial frame with no Enable or FrameErr pulse; the bus SHALL re-acquire on the next start bit.

Configuration
REQ-026 Macro PS2_PARITY_CHECK_EN: when defined, parity SHALL be checked as in REQ-017.
REQ-027 When PS2_PARITY_CHECK_EN is undefined, the parity bit SHALL be sampled and ignored; only a bad stop bit or a timeout SHALL discard a frame.

Structure
REQ-028 Package ps2_pkg SHALL hold the FSM state encoding and the scan constants KEYUP 0xF0, START 0x5A, STOP 0x76, DOWN 0x72 and UP 0x75, shared with the sound state machine.
REQ-029 The synchronizer and glitch filter SHALL be one sub-module, ps2_sync_filter, instantiated once per input line (the data instance uses filter length 1).

Verification
REQ-030 Valid frame for byte 0x5A (parity 1, stop 1) -> Keycode = 0x5A, one Enable pulse, FrameErr stays 0.
REQ-031 Byte 0x75 sent with parity 1 (even) -> with PS2_PARITY_CHECK_EN: no Enable, one FrameErr, Keycode keeps its old value; without it: Keycode = 0x75 and one Enable.
REQ-032 Back-to-back frames 0xF0 then 0x72 -> exactly two Enable pulses, with Keycode 0xF0 and then 0x72.
REQ-033 Start bit plus 4 data bits, then PS2Clk held high for 100001 cycles -> one FrameErr, state IDLE, and the next 0x76 frame is accepted.
REQ-034 A 5-cycle low glitch on PS2Clk while IDLE -> no state change, no strobes.
REQ-035 Reset asserted after 3 data bits, then a full 0x72 frame -> no strobe during reset, then Keycode = 0x72 with one Enable.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM encoding and the scan codes the sound FSM reacts to.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] KEYUP = 8'hF0;
    localparam logic [7:0] START = 8'h5A;
    localparam logic [7:0] STOP  = 8'h76;
    localparam logic [7:0] DOWN  = 8'h72;
    localparam logic [7:0] UP    = 8'h75;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer plus a hold-time glitch filter for one PS/2 line.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic filt
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    // Lines idle high, so everything resets to 1 to avoid a false edge after reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            filt  <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Define PS2_PARITY_CHECK_EN to discard frames with bad parity.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic [7:0] Keycode,
    output logic       Enable,
    output logic       FrameErr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_f, clk_q, data_f, bit_event, frame_ok;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] tcnt;
    ps2_state_e    state;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .Clock(Clock), .Reset(Reset), .raw(PS2Clk), .filt(clk_f)
    );

    ps2_sync_filter #(.FILTER_LEN(1)) u_data_filt (
        .Clock(Clock), .Reset(Reset), .raw(PS2Data), .filt(data_f)
    );

    assign bit_event = clk_q & ~clk_f;

`ifdef PS2_PARITY_CHECK_EN
    logic parity;
    assign frame_ok = data_f & (^{shift, parity});
`else
    assign frame_ok = data_f;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            clk_q    <= 1'b1;
            shift    <= '0;
            bit_cnt  <= '0;
            tcnt     <= '0;
            Keycode  <= 8'h00;
            Enable   <= 1'b0;
            FrameErr <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity   <= 1'b0;
`endif
        end else begin
            clk_q    <= clk_f;
            Enable   <= 1'b0;
            FrameErr <= 1'b0;
            // A bit event wins over a timeout landing in the same cycle.
            if (bit_event) begin
                tcnt <= '0;
                case (state)
                    ST_IDLE: if (!data_f) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                    ST_DATA: begin
                        shift   <= {data_f, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity <= data_f;
`endif
                        state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (frame_ok) begin
                            Keycode <= shift;
                            Enable  <= 1'b1;
                        end else begin
                            FrameErr <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state == ST_IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
                state    <= ST_IDLE;
                tcnt     <= '0;
                FrameErr <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx; expectations follow PS2_PARITY_CHECK_EN if defined.
module tb_ps2_keycode_rx;
    import ps2_pkg::*;

    localparam int TMO  = 1000;
    localparam int HALF = 20;

    typedef struct {
        bit       err;
        bit [7:0] code;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       PS2Clk = 1'b1;
    logic       PS2Data = 1'b1;
    logic [7:0] Keycode;
    logic       Enable, FrameErr;

    exp_t     sb[$];
    int       checks = 0;
    int       failures = 0;
    int       cyc = 0;
    int       stop_cyc = 0;
    int       en_cyc = 0;
    bit [7:0] exp_kc = 8'h00;

    ps2_keycode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock(Clock), .Reset(Reset), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
        .Keycode(Keycode), .Enable(Enable), .FrameErr(FrameErr)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // Output monitor: every strobe must match the oldest pending expectation.
    always @(negedge Clock) begin
        if (Enable || FrameErr) begin
            checks = checks + 1;
            if (Enable && FrameErr) begin
                failures = failures + 1;
                $display("FAIL strobe_overlap: Enable=%b FrameErr=%b, required not both", Enable, FrameErr);
            end else if (sb.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_strobe: Enable=%b FrameErr=%b Keycode=%h, required no strobe",
                         Enable, FrameErr, Keycode);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (Enable) en_cyc = cyc;
                if (FrameErr !== e.err || (!e.err && Keycode !== e.code)) begin
                    failures = failures + 1;
                    $display("FAIL strobe_content: err=%b code=%h, required err=%b code=%h",
                             FrameErr, Keycode, e.err, e.code);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic send_bit(input bit b);
        PS2Data = b;
        wait_cycles(HALF);
        PS2Clk = 1'b0;
        if (b === 1'b1 && 0) PS2Data = b;
        wait_cycles(HALF);
        PS2Clk = 1'b1;
    endtask

    // Sends the first nbits bits of a frame (11 = complete frame).
    task automatic send_frame(input bit [7:0] b, input bit par, input bit stp, input int nbits);
        bit [10:0] f;
        f = {stp, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2Data = f[i];
            wait_cycles(HALF);
            PS2Clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cycles(HALF);
            PS2Clk = 1'b1;
        end
        PS2Data = 1'b1;
    endtask

    task automatic expect_ok(input bit [7:0] b);
        exp_t e;
        e.err = 1'b0; e.code = b;
        sb.push_back(e);
        exp_kc = b;
    endtask

    task automatic expect_err();
        exp_t e;
        e.err = 1'b1; e.code = 8'h00;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        wait_cycles(3 * HALF);
        checks = checks + 1;
        if (sb.size() != 0) begin
            failures = failures + 1;
            $display("FAIL %s_missing: %0d strobes still pending, required 0", name, sb.size());
            sb.delete();
        end
        checks = checks + 1;
        if (Keycode !== exp_kc) begin
            failures = failures + 1;
            $display("FAIL %s_keycode: Keycode=%h, required %h", name, Keycode, exp_kc);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        wait_cycles(5);
        checks = checks + 1;
        if (Keycode !== 8'h00 || Enable !== 1'b0 || FrameErr !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL reset_outputs: Keycode=%h Enable=%b FrameErr=%b, required 00 0 0",
                     Keycode, Enable, FrameErr);
        end
        Reset = 1'b0;
        wait_cycles(20);
    endtask

    task automatic test_valid();
        expect_ok(START);
        send_frame(START, ~^START, 1'b1, 11);
        drain("valid_5a");
        checks = checks + 1;
        if (en_cyc - stop_cyc < 10 || en_cyc - stop_cyc > 12) begin
            failures = failures + 1;
            $display("FAIL latency: %0d cycles, required 10..12", en_cyc - stop_cyc);
        end
        expect_ok(8'h00);
        send_frame(8'h00, 1'b1, 1'b1, 11);
        drain("valid_00");
        expect_ok(8'hFF);
        send_frame(8'hFF, 1'b1, 1'b1, 11);
        drain("valid_ff");
    endtask

    task automatic test_parity();
`ifdef PS2_PARITY_CHECK_EN
        expect_err();
`else
        expect_ok(UP);
`endif
        send_frame(UP, 1'b1, 1'b1, 11);
        drain("parity_75");
    endtask

    task automatic test_bad_stop();
        expect_err();
        send_frame(STOP, ~^STOP, 1'b0, 11);
        drain("bad_stop");
    endtask

    task automatic test_back_to_back();
        expect_ok(KEYUP);
        expect_ok(DOWN);
        send_frame(KEYUP, ~^KEYUP, 1'b1, 11);
        send_frame(DOWN, ~^DOWN, 1'b1, 11);
        drain("b2b");
    endtask

    task automatic test_timeout();
        expect_err();
        send_frame(8'hA5, 1'b0, 1'b1, 5);
        wait_cycles(TMO + 100);
        drain("timeout");
        expect_ok(STOP);
        send_frame(STOP, ~^STOP, 1'b1, 11);
        drain("after_timeout");
    endtask

    task automatic test_glitch();
        PS2Data = 1'b0;
        wait_cycles(5);
        PS2Clk = 1'b0;
        wait_cycles(5);
        PS2Clk = 1'b1;
        wait_cycles(5);
        PS2Data = 1'b1;
        drain("glitch");
        expect_ok(DOWN);
        send_frame(DOWN, ~^DOWN, 1'b1, 11);
        drain("after_glitch");
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h3C, 1'b1, 1'b1, 4);
        wait_cycles(5);
        Reset = 1'b1;
        exp_kc = 8'h00;
        wait_cycles(5);
        Reset = 1'b0;
        drain("reset_mid");
        expect_ok(DOWN);
        send_frame(DOWN, ~^DOWN, 1'b1, 11);
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_valid();
        test_parity();
        test_bad_stop();
        test_back_to_back();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
